// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty flags and sticky overflow/underflow.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads have 1-cycle latency.
module sync_fifo #(
  parameter int unsigned DATASIZE      = 8,
  parameter int unsigned ADDRSIZE      = 4,
  parameter int unsigned AFULL_THRESH  = (1 << ADDRSIZE) - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                wfull,
  output logic                rempty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow,
  input  logic                err_clr
);

  localparam int unsigned DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] AFULL_C  = AFULL_THRESH[ADDRSIZE:0];
  localparam logic [ADDRSIZE:0] AEMPTY_C = AEMPTY_THRESH[ADDRSIZE:0];

  logic [DATASIZE-1:0] mem [DEPTH];

  logic [ADDRSIZE:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic                wfull_q, wfull_d, rempty_q, rempty_d;
  logic                afull_q, afull_d, aempty_q, aempty_d;
  logic                overflow_q, overflow_d, underflow_q, underflow_d;
  logic [DATASIZE-1:0] rdata_q;
  logic                wr_en, rd_en;
  logic                rd_load, rd_bypass;
  logic [ADDRSIZE-1:0] rd_addr;

  always_comb begin
    wr_en       = winc & ~wfull_q;
    rd_en       = rinc & ~rempty_q;
    wptr_d      = wptr_q + {{ADDRSIZE{1'b0}}, wr_en};
    rptr_d      = rptr_q + {{ADDRSIZE{1'b0}}, rd_en};
    count_d     = count_q + {{ADDRSIZE{1'b0}}, wr_en} - {{ADDRSIZE{1'b0}}, rd_en};
    rempty_d    = (wptr_d == rptr_d);
    wfull_d     = (wptr_d[ADDRSIZE-1:0] == rptr_d[ADDRSIZE-1:0]) &&
                  (wptr_d[ADDRSIZE] != rptr_d[ADDRSIZE]);
    afull_d     = (count_d >= AFULL_C);
    aempty_d    = (count_d <= AEMPTY_C);
    // A new error in the same cycle as err_clr keeps the flag set.
    overflow_d  = (overflow_q & ~err_clr) | (winc & wfull_q);
    underflow_d = (underflow_q & ~err_clr) | (rinc & rempty_q);
`ifdef SYNC_FIFO_FWFT_EN
    // Preload the word that will be at the head after this edge; forward wdata
    // when that word is the one being written right now.
    rd_load   = ~rempty_d;
    rd_addr   = rptr_d[ADDRSIZE-1:0];
    rd_bypass = wr_en && (rptr_d == wptr_q);
`else
    rd_load   = rd_en;
    rd_addr   = rptr_q[ADDRSIZE-1:0];
    rd_bypass = 1'b0;
`endif
  end

  always_ff @(posedge wclk) begin
    if (wr_en) begin
      mem[wptr_q[ADDRSIZE-1:0]] <= wdata;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      wfull_q     <= 1'b0;
      rempty_q    <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      wfull_q     <= wfull_d;
      rempty_q    <= rempty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      if (rd_load) begin
        rdata_q <= rd_bypass ? wdata : mem[rd_addr];
      end
    end
  end

  assign rdata        = rdata_q;
  assign wfull        = wfull_q;
  assign rempty       = rempty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo in its default (registered-read) build.
`timescale 1ns/1ps
module tb_sync_fifo;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       winc = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       rinc = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rdata;
  logic       wfull, rempty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;

  sync_fifo #(.DATASIZE(8), .ADDRSIZE(4)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
    .rdata(rdata), .wfull(wfull), .rempty(rempty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr)
  );

  always #5 wclk = ~wclk;

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    winc = 1'b1; wdata = d;
    tick();
    winc = 1'b0;
  endtask

  task automatic pop();
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
  endtask

  task automatic test_reset();
    wrst_n = 1'b0;
    tick(); tick();
    checks++;
    if (count !== 5'd0 || rempty !== 1'b1 || wfull !== 1'b0 || almost_empty !== 1'b1 ||
        almost_full !== 1'b0 || rdata !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: count=%0d rempty=%b wfull=%b ae=%b af=%b rdata=%h ovf=%b udf=%b required 0 1 0 1 0 00 0 0",
               count, rempty, wfull, almost_empty, almost_full, rdata, overflow, underflow);
    end
    wrst_n = 1'b1;
    tick();
    $display("reset: count=%0d rempty=%b", count, rempty);
  endtask

  task automatic test_single();
    push(8'hAA);
    checks++;
    if (count !== 5'd1 || rempty !== 1'b0) begin
      errors++;
      $display("FAIL single_write: count=%0d rempty=%b required 1 0", count, rempty);
    end
    pop();
    checks++;
    if (rdata !== 8'hAA || count !== 5'd0 || rempty !== 1'b1) begin
      errors++;
      $display("FAIL single_read: rdata=%h count=%0d rempty=%b required aa 0 1", rdata, count, rempty);
    end
    $display("single: rdata=%h count=%0d", rdata, count);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      checks++;
      if (count !== 5'(i + 1) || wfull !== (i == 15) || almost_full !== (i + 1 >= 14) ||
          almost_empty !== (i + 1 <= 2)) begin
        errors++;
        $display("FAIL fill_%0d: count=%0d wfull=%b af=%b ae=%b required %0d %b %b %b", i, count, wfull,
                 almost_full, almost_empty, i + 1, (i == 15), (i + 1 >= 14), (i + 1 <= 2));
      end
    end
    push(8'hEE);
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16 || wfull !== 1'b1) begin
      errors++;
      $display("FAIL fill_overflow: ovf=%b count=%0d wfull=%b required 1 16 1", overflow, count, wfull);
    end
    for (int i = 0; i < 16; i++) begin
      pop();
      checks++;
      if (rdata !== 8'(i) || count !== 5'(15 - i)) begin
        errors++;
        $display("FAIL drain_%0d: rdata=%h count=%0d required %h %0d", i, rdata, count, 8'(i), 15 - i);
      end
    end
    checks++;
    if (rempty !== 1'b1 || wfull !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: rempty=%b wfull=%b required 1 0", rempty, wfull);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill_clear: ovf=%b required 0", overflow);
    end
    $display("fill: done count=%0d", count);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) push(8'hC0 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      pop();
      checks++;
      if (rdata !== 8'hC0 + 8'(i)) begin
        errors++;
        $display("FAIL wrap_pre_%0d: rdata=%h required %h", i, rdata, 8'hC0 + 8'(i));
      end
    end
    for (int i = 0; i < 16; i++) begin
      push(8'h10 + 8'(i));
      checks++;
      if (wfull !== (i == 15) || count !== 5'(i + 1)) begin
        errors++;
        $display("FAIL wrap_fill_%0d: wfull=%b count=%0d required %b %0d", i, wfull, count, (i == 15), i + 1);
      end
    end
    for (int i = 0; i < 16; i++) begin
      pop();
      checks++;
      if (rdata !== 8'h10 + 8'(i)) begin
        errors++;
        $display("FAIL wrap_read_%0d: rdata=%h required %h", i, rdata, 8'h10 + 8'(i));
      end
    end
    $display("wrap: rempty=%b count=%0d", rempty, count);
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) push(8'h20 + 8'(i));
    for (int k = 0; k < 20; k++) begin
      winc = 1'b1; rinc = 1'b1; wdata = 8'h25 + 8'(k);
      tick();
      checks++;
      if (rdata !== 8'h20 + 8'(k) || count !== 5'd5) begin
        errors++;
        $display("FAIL simul_%0d: rdata=%h count=%0d required %h 5", k, rdata, count, 8'h20 + 8'(k));
      end
    end
    winc = 1'b0; rinc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pop();
      checks++;
      if (rdata !== 8'h34 + 8'(i)) begin
        errors++;
        $display("FAIL simul_drain_%0d: rdata=%h required %h", i, rdata, 8'h34 + 8'(i));
      end
    end
    winc = 1'b1; rinc = 1'b1; wdata = 8'h77;
    tick();
    winc = 1'b0; rinc = 1'b0;
    checks++;
    if (count !== 5'd1 || underflow !== 1'b1 || rdata !== 8'h38 || rempty !== 1'b0) begin
      errors++;
      $display("FAIL simul_empty: count=%0d udf=%b rdata=%h rempty=%b required 1 1 38 0", count, underflow, rdata, rempty);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL udf_clear: udf=%b required 0", underflow);
    end
    for (int i = 0; i < 15; i++) push(8'h80 + 8'(i));
    winc = 1'b1; rinc = 1'b1; wdata = 8'hFF;
    tick();
    winc = 1'b0; rinc = 1'b0;
    checks++;
    if (count !== 5'd15 || overflow !== 1'b1 || rdata !== 8'h77 || wfull !== 1'b0) begin
      errors++;
      $display("FAIL simul_full: count=%0d ovf=%b rdata=%h wfull=%b required 15 1 77 0", count, overflow, rdata, wfull);
    end
    $display("simultaneous: count=%0d ovf=%b", count, overflow);
  endtask

  task automatic test_sticky_clear();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear: ovf=%b required 0", overflow);
    end
    push(8'h90);
    winc = 1'b1; err_clr = 1'b1; wdata = 8'h91;
    tick();
    winc = 1'b0; err_clr = 1'b0;
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      errors++;
      $display("FAIL sticky_set_wins: ovf=%b count=%0d required 1 16", overflow, count);
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    $display("sticky: ovf=%b count=%0d", overflow, count);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 7; i++) pop();
    checks++;
    if (count !== 5'd9) begin
      errors++;
      $display("FAIL mid_reset_setup: count=%0d required 9", count);
    end
    #2 wrst_n = 1'b0;
    #1;
    checks++;
    if (count !== 5'd0 || rempty !== 1'b1 || wfull !== 1'b0 || almost_empty !== 1'b1 ||
        almost_full !== 1'b0 || rdata !== 8'h00 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: count=%0d rempty=%b wfull=%b ae=%b af=%b rdata=%h ovf=%b required 0 1 0 1 0 00 0",
               count, rempty, wfull, almost_empty, almost_full, rdata, overflow);
    end
    #2 wrst_n = 1'b1;
    tick();
    push(8'h55);
    pop();
    checks++;
    if (rdata !== 8'h55 || count !== 5'd0 || rempty !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_after: rdata=%h count=%0d rempty=%b required 55 0 1", rdata, count, rempty);
    end
    $display("mid_reset: rdata=%h", rdata);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_simultaneous();
    test_sticky_clear();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
